// File: rtl/display_source_arbiter.sv
// Chooses what the 8-digit display shows (time, alarm or a timed message).
// Also generates the edit and alarm-ring blink masks; every output is registered.
module display_source_arbiter #(
  parameter int MSG_CYCLES = 200000000,
  parameter int BLINK_HALF = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] time_digits,
  input  logic [31:0] alarm_digits,
  input  logic        show_alarm,
  input  logic        msg_req,
  input  logic [31:0] msg_digits,
  input  logic        msg_cancel,
  input  logic [7:0]  edit_mask,
  input  logic        alarm_ring,
  output logic [31:0] disp_digits,
  output logic [7:0]  disp_blank,
  output logic [1:0]  src,
  output logic        msg_busy
);

  localparam int MW = $clog2(MSG_CYCLES);
  localparam int BW = $clog2(BLINK_HALF);
  localparam logic [MW-1:0] MSG_LAST   = MW'(MSG_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    S_TIME  = 2'd0,
    S_ALARM = 2'd1,
    S_MSG   = 2'd2
  } state_t;

  state_t        state, state_nxt, view;
  logic [MW-1:0] msg_cnt, msg_cnt_nxt;
  logic [31:0]   msg_buf, msg_buf_nxt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_on, blink_on_nxt;
  logic          edit_nz_q, ring_q, blink_restart;
  logic [31:0]   digits_d;
  logic [7:0]    blank_d;

  // State and message datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_TIME;
      msg_cnt <= '0;
      msg_buf <= '0;
    end else begin
      state   <= state_nxt;
      msg_cnt <= msg_cnt_nxt;
      msg_buf <= msg_buf_nxt;
    end
  end

  // Cancel beats a same-cycle request; a request beats expiry
  always_comb begin
    view        = show_alarm ? S_ALARM : S_TIME;
    state_nxt   = state;
    msg_cnt_nxt = msg_cnt;
    msg_buf_nxt = msg_buf;
    if (state == S_MSG && msg_cancel) begin
      state_nxt = view;
    end else if (msg_req) begin
      state_nxt   = S_MSG;
      msg_cnt_nxt = MSG_LAST;
      msg_buf_nxt = msg_digits;
    end else if (state == S_MSG) begin
      if (msg_cnt == '0) state_nxt = view;
      else               msg_cnt_nxt = msg_cnt - 1'b1;
    end else begin
      state_nxt = view;
    end
  end

  // Restarting the blink makes the first phase after an edit/ring start visible
  always_comb begin
    blink_restart = ((edit_mask != 8'h00) && !edit_nz_q) || (alarm_ring && !ring_q);
    blink_cnt_nxt = blink_cnt + 1'b1;
    blink_on_nxt  = blink_on;
    if (blink_restart) begin
      blink_cnt_nxt = '0;
      blink_on_nxt  = 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_nxt = '0;
      blink_on_nxt  = ~blink_on;
    end
  end

  always_comb begin
    case (state_nxt)
      S_MSG:   digits_d = msg_buf_nxt;
      S_ALARM: digits_d = alarm_digits;
      default: digits_d = time_digits;
    endcase
    if (state_nxt == S_MSG)  blank_d = 8'h00;
    else if (alarm_ring)     blank_d = blink_on_nxt ? 8'h00 : 8'hFF;
    else                     blank_d = blink_on_nxt ? 8'h00 : edit_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      edit_nz_q   <= 1'b0;
      ring_q      <= 1'b0;
      disp_digits <= '0;
      disp_blank  <= 8'h00;
      src         <= 2'd0;
      msg_busy    <= 1'b0;
    end else begin
      blink_cnt   <= blink_cnt_nxt;
      blink_on    <= blink_on_nxt;
      edit_nz_q   <= (edit_mask != 8'h00);
      ring_q      <= alarm_ring;
      disp_digits <= digits_d;
      disp_blank  <= blank_d;
      src         <= state_nxt;
      msg_busy    <= (state_nxt == S_MSG);
    end
  end

endmodule

// File: tb/tb_display_source_arbiter.sv
// Scoreboard bench for display_source_arbiter: a cycle model queues expected outputs per clock.
module tb_display_source_arbiter;
  localparam int MSGC = 10;
  localparam int BH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] time_digits = '0, alarm_digits = '0, msg_digits = '0;
  logic        show_alarm = 1'b0, msg_req = 1'b0, msg_cancel = 1'b0, alarm_ring = 1'b0;
  logic [7:0]  edit_mask = '0;
  logic [31:0] disp_digits;
  logic [7:0]  disp_blank;
  logic [1:0]  src;
  logic        msg_busy;

  always #5 clk = ~clk;

  display_source_arbiter #(.MSG_CYCLES(MSGC), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .time_digits(time_digits), .alarm_digits(alarm_digits),
    .show_alarm(show_alarm), .msg_req(msg_req), .msg_digits(msg_digits),
    .msg_cancel(msg_cancel), .edit_mask(edit_mask), .alarm_ring(alarm_ring),
    .disp_digits(disp_digits), .disp_blank(disp_blank), .src(src), .msg_busy(msg_busy)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  b;
    logic [1:0]  s;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  int busy_cnt = 0;

  // model state: m_left = message cycles remaining including the one on display
  logic [1:0]  m_src = 2'd0;
  int          m_left = 0, m_ph = 0;
  logic [31:0] m_buf = '0;
  logic        m_edit_nz = 1'b0, m_ring = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_src = 2'd0; m_left = 0; m_ph = 0; m_buf = '0; m_edit_nz = 1'b0; m_ring = 1'b0;
  endtask

  task automatic step();
    exp_t e;
    logic on;
    logic [1:0] view;
    view = show_alarm ? 2'd1 : 2'd0;
    if (m_src == 2'd2 && msg_cancel) m_src = view;
    else if (msg_req) begin
      m_src = 2'd2; m_left = MSGC; m_buf = msg_digits;
    end else if (m_src == 2'd2) begin
      if (m_left == 1) m_src = view;
      else m_left--;
    end else m_src = view;
    if ((edit_mask != 8'h00 && !m_edit_nz) || (alarm_ring && !m_ring)) m_ph = 0;
    else m_ph = (m_ph + 1) % (2 * BH);
    m_edit_nz = (edit_mask != 8'h00);
    m_ring = alarm_ring;
    on = (m_ph < BH);
    e.s = m_src;
    e.busy = (m_src == 2'd2);
    e.d = (m_src == 2'd2) ? m_buf : (m_src == 2'd1) ? alarm_digits : time_digits;
    if (m_src == 2'd2) e.b = 8'h00;
    else if (alarm_ring) e.b = on ? 8'h00 : 8'hFF;
    else e.b = on ? 8'h00 : edit_mask;
    sb.push_back(e);

    @(posedge clk);
    #1;
    msg_req = 1'b0;
    msg_cancel = 1'b0;
    if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      check("digits", disp_digits, e.d);
      check("blank", {24'd0, disp_blank}, {24'd0, e.b});
      check("src", {30'd0, src}, {30'd0, e.s});
      check("busy", {31'd0, msg_busy}, {31'd0, e.busy});
    end
    if (msg_busy) busy_cnt++;
  endtask

  task automatic send(input logic [31:0] md);
    msg_req = 1'b1;
    msg_digits = md;
  endtask

  initial begin
    #12;
    check("rst_digits", disp_digits, 32'h0);
    check("rst_blank", {24'd0, disp_blank}, 32'h0);
    check("rst_src", {30'd0, src}, 32'h0);
    check("rst_busy", {31'd0, msg_busy}, 32'h0);
    time_digits = 32'h00123045;
    rst = 1'b0;
    model_reset();

    step();
    check("time_view", disp_digits, 32'h00123045);
    show_alarm = 1'b1;
    alarm_digits = 32'h00000630;
    step();
    check("alarm_view", disp_digits, 32'h00000630);
    check("alarm_src", {30'd0, src}, 32'd1);

    // basic message while time counts underneath
    busy_cnt = 0;
    send(32'hABCDEF01);
    for (int i = 0; i < 14; i++) begin
      time_digits = time_digits + 1;
      step();
    end
    check("msg_len", busy_cnt, MSGC);
    check("msg_exit_src", {30'd0, src}, 32'd1);

    // restart on the 6th message cycle
    busy_cnt = 0;
    send(32'hABCDEF01);
    for (int i = 0; i < 6; i++) step();
    send(32'h11112222);
    step();
    check("restart_content", disp_digits, 32'h11112222);
    for (int i = 0; i < 14; i++) step();
    check("restart_len", busy_cnt, 16);

    // request landing on the expiry cycle
    busy_cnt = 0;
    send(32'h55556666);
    for (int i = 0; i < 10; i++) step();
    send(32'h77778888);
    for (int i = 0; i < 15; i++) step();
    check("expiry_req_len", busy_cnt, 20);

    // cancel on 3rd cycle, then cancel together with request
    busy_cnt = 0;
    send(32'h0000CAFE);
    step(); step(); step();
    msg_cancel = 1'b1;
    step();
    check("cancel_len", busy_cnt, 3);
    send(32'h0000BEEF);
    step();
    msg_cancel = 1'b1;
    send(32'h0000DEAD);
    step();
    check("cancel_req_src", {30'd0, src}, 32'd1);
    step();

    // edit blink in TIME view with a message in the middle
    show_alarm = 1'b0;
    step();
    edit_mask = 8'h0C;
    for (int i = 0; i < 12; i++) step();
    send(32'h12345678);
    for (int i = 0; i < 14; i++) step();

    // alarm ring overrides the edit mask
    alarm_ring = 1'b1;
    edit_mask = 8'h03;
    for (int i = 0; i < 10; i++) step();

    // asynchronous reset mid-phase
    rst = 1'b1;
    #1;
    check("arst_digits", disp_digits, 32'h0);
    check("arst_blank", {24'd0, disp_blank}, 32'h0);
    check("arst_src", {30'd0, src}, 32'h0);
    check("arst_busy", {31'd0, msg_busy}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    show_alarm = 1'b1;
    rst = 1'b0;
    step();
    check("post_rst_src", {30'd0, src}, 32'd1);
    for (int i = 0; i < 10; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/display_source_arbiter.md
Name: display_source_arbiter

Overview:
- Decides what the 8-digit seven-segment display shows and when each digit is blanked.
- Arbitrates between three sources:
  - live time digits;
  - alarm-setting digits;
  - a transient message with a fixed hold time.
- Generates the blink timing for field editing and for alarm ringing.
- Drives the 32-bit digit bus and 8-bit blank mask consumed by the seven-segment scan/decode path.

Parameters:
- MSG_CYCLES, 200000000: clock cycles a message is held (2 s at 100 MHz); minimum 2.
- BLINK_HALF, 25000000: clock cycles per blink half-period (2 Hz blink at 100 MHz); minimum 2.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  asynchronous reset, active-high.
- time_digits  in  32  8 BCD/hex nibbles of current time; nibble 0 = rightmost digit.
- alarm_digits  in  32  8 nibbles of the alarm setting.
- show_alarm  in  1  level; 1 selects the alarm view, 0 selects the time view.
- msg_req  in  1  single-cycle pulse; request to show msg_digits.
- msg_digits  in  32  message nibbles; sampled only in a cycle where msg_req=1.
- msg_cancel  in  1  single-cycle pulse; ends the current message immediately.
- edit_mask  in  8  digits currently being edited; these blink.
- alarm_ring  in  1  level; when 1, the whole display blinks.
- disp_digits  out  32  registered digit bus to the display path.
- disp_blank  out  8  registered per-digit blank; 1 = digit dark.
- src  out  2  registered active source: 0 = time, 1 = alarm, 2 = message.
- msg_busy  out  1  registered; 1 while in the MSG state.

Behaviour:
- State machine: TIME, ALARM, MSG.
  - Reset enters TIME.
- Transitions, evaluated every cycle in priority order:
  1. msg_cancel=1 while in MSG: leave MSG this cycle; next state = ALARM if show_alarm else TIME. Any msg_req in the same cycle is dropped.
  2. msg_req=1 in any state:
     - next state = MSG;
     - latch msg_digits into msg_buf;
     - load msg_cnt = MSG_CYCLES-1.
     - If already in MSG, this restarts the hold and replaces the content.
  3. In MSG with msg_cnt=0: return to ALARM if show_alarm else TIME.
     - A msg_req in this same cycle wins per rule 2: stay in MSG and reload.
  4. In MSG with msg_cnt>0: decrement msg_cnt.
  5. In TIME/ALARM: follow show_alarm (1 = ALARM, 0 = TIME) every cycle.
     - show_alarm changes during MSG are not acted on until MSG exits.
- Message hold: MSG lasts exactly MSG_CYCLES cycles, counted from the first cycle with src=2 to the last.
- Output latency:
  - disp_digits, src and msg_busy reflect the state and source data registered one cycle after the controlling input edge.
  - In TIME/ALARM, disp_digits tracks time_digits/alarm_digits with 1-cycle latency.
  - In MSG, disp_digits = msg_buf; it is frozen while the live inputs change.
- Blink generator:
  - blink_cnt counts 0..BLINK_HALF-1, then wraps.
  - blink_on toggles at each wrap.
  - Reset value: blink_cnt=0, blink_on=1.
  - Restart to blink_cnt=0, blink_on=1 whenever edit_mask goes from 0 to nonzero, or on the rising edge of alarm_ring. This makes the first phase visible.
- disp_blank, registered:
  - src=2: 8'h00 (messages never blink).
  - Else if alarm_ring=1: 8'hFF when blink_on=0, otherwise 8'h00.
  - Else: edit_mask when blink_on=0, otherwise 8'h00.
- Reset values: disp_digits=0, disp_blank=8'h00, src=0, msg_busy=0, msg_cnt=0, msg_buf=0, blink_cnt=0, blink_on=1.
- Reset mid-message: the message is discarded; after reset release the block is in TIME, or in ALARM on the first cycle if show_alarm=1.
- Counter widths: msg_cnt and blink_cnt are sized as clog2 of their parameter. No overflow is possible; there is no saturation logic.

Test Plan (MSG_CYCLES=10, BLINK_HALF=4):
- Reset, then time_digits=32'h00123045, show_alarm=0:
  - src=0 and disp_digits=32'h00123045 one cycle later.
  - Toggle show_alarm=1 with alarm_digits=32'h00000630: src=1 and disp_digits=32'h00000630 after 1 cycle.
- msg_req pulse with msg_digits=32'hABCDEF01:
  - src=2 and msg_busy=1 for exactly 10 cycles with disp_digits=32'hABCDEF01, while time_digits increments underneath.
  - Then src returns to the show_alarm view.
- Second msg_req with 32'h11112222 on the 6th MSG cycle: content changes to 32'h11112222 next cycle, and MSG lasts 10 further cycles.
  - Repeat with msg_req landing on the expiry cycle: MSG continues without a gap.
- msg_cancel on the 3rd MSG cycle: src returns to time/alarm the next cycle.
  - msg_cancel together with msg_req: message cleared, request ignored.
- edit_mask 8'h00 to 8'h0C in TIME:
  - disp_blank = 00 for 4 cycles, 0C for 4 cycles, repeating.
  - A msg_req during this period forces disp_blank=00 while src=2.
- alarm_ring=1 with edit_mask=8'h03: disp_blank alternates 00/FF every 4 cycles starting with 00.
  - Assert rst mid-phase: all outputs return to their reset values asynchronously, without waiting for a clock edge.
